// File: rtl/ram_single_arbiter.sv
// ram_single_arbiter
//   Two-requester round-robin arbiter and access sequencer for a single-port
//   synchronous RAM with active-low chip select / write enable.
//   Each requester issues one read or write at a time with a level request
//   and receives a one-cycle grant pulse while its access is on the RAM.
//   Read data is returned registered with a one-cycle valid strobe.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN     requester N transaction (N = 0, 1)
//   gntN                         grant pulse: requester N access on RAM now
//   rvalidN, rdataN              read result strobe / held read data
//   ram_addm, ram_cs_n,
//   ram_we_n, ram_din            RAM command port (all registered)
//   ram_dout                     RAM read data, valid the cycle after a read
module ram_single_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addm,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDCAP
    } state_t;

    state_t              r_state;
    logic                r_rr_last;
    logic                r_win;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic [ADDR_W-1:0]   r_ram_addm;
    logic                r_ram_cs_n;
    logic                r_ram_we_n;
    logic [DATA_W-1:0]   r_ram_din;

    logic                w_any;
    logic                w_win;

    // Winner: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_any = req0 | req1;
        if (req0 && req1) begin
            w_win = ~r_rr_last;
        end else begin
            w_win = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_last  <= 1'b1;
            r_win      <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_ram_addm <= '0;
            r_ram_cs_n <= 1'b1;
            r_ram_we_n <= 1'b1;
            r_ram_din  <= '0;
        end else begin
            // Valid strobes last exactly one cycle (the IDLE after RDCAP).
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ram_addm <= w_win ? addr1  : addr0;
                        r_ram_din  <= w_win ? wdata1 : wdata0;
                        r_ram_we_n <= w_win ? ~we1   : ~we0;
                        r_ram_cs_n <= 1'b0;
                        r_gnt0     <= ~w_win;
                        r_gnt1     <= w_win;
                        r_rr_last  <= w_win;
                        r_win      <= w_win;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ram_cs_n <= 1'b1;
                    r_ram_we_n <= 1'b1;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    // ram_we_n still holds the command of this access here.
                    r_state    <= r_ram_we_n ? RDCAP : IDLE;
                end
                RDCAP: begin
                    if (r_win) begin
                        r_rdata1  <= ram_dout;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= ram_dout;
                        r_rvalid0 <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign ram_addm = r_ram_addm;
    assign ram_cs_n = r_ram_cs_n;
    assign ram_we_n = r_ram_we_n;
    assign ram_din  = r_ram_din;

endmodule

// File: tb/tb_ram_single_arbiter.sv
// tb_ram_single_arbiter
//   Directed bench for ram_single_arbiter with a behavioural 8x8 RAM.
//   Stimulus pushes expected grants / read results; a negedge monitor pops
//   and compares whenever the arbiter presents gnt or rvalid.
module tb_ram_single_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, we0, gnt0, rvalid0;
    logic [2:0] addr0;
    logic [7:0] wdata0, rdata0;
    logic       req1, we1, gnt1, rvalid1;
    logic [2:0] addr1;
    logic [7:0] wdata1, rdata1;
    logic [2:0] ram_addm;
    logic       ram_cs_n, ram_we_n;
    logic [7:0] ram_din, ram_dout;

    ram_single_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .ram_addm (ram_addm),
        .ram_cs_n (ram_cs_n),
        .ram_we_n (ram_we_n),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural single-port synchronous RAM.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_addm] <= ram_din;
            else           ram_dout <= mem[ram_addm];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic       we;
        logic [2:0] a;
        logic [7:0] d;
        int         c;
    } gexp_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq0[$];
    rexp_t rq1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_g(input int id, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input int c);
        gexp_t e;
        e.id = id; e.we = we; e.a = a; e.d = d; e.c = c;
        gq.push_back(e);
    endtask

    task automatic exp_r(input int id, input logic [7:0] d, input int c);
        rexp_t e;
        e.d = d; e.c = c;
        if (id == 0) rq0.push_back(e);
        else         rq1.push_back(e);
    endtask

    // Monitor: compares every grant / read strobe against the scoreboard.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (ram_cs_n) chk("we_n_when_deselected", {31'd0, ram_we_n}, 32'd1);
        if (gnt0 && gnt1) chk("dual_grant", 32'd1, 32'd0);
        if (gnt0 || gnt1) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
                g = gq.pop_front();
                chk("gnt_id", {31'd0, gnt1}, g.id);
                chk("gnt_cycle", cyc, g.c);
                chk("gnt_cs_n", {31'd0, ram_cs_n}, 32'd0);
                chk("gnt_we_n", {31'd0, ram_we_n}, {31'd0, ~g.we});
                chk("gnt_addr", {29'd0, ram_addm}, {29'd0, g.a});
                if (g.we) chk("gnt_din", {24'd0, ram_din}, {24'd0, g.d});
            end
        end
        if (rvalid0) begin
            if (rq0.size() == 0) begin
                chk("unexpected_rvalid0", 32'd1, 32'd0);
            end else begin
                r = rq0.pop_front();
                chk("rdata0", {24'd0, rdata0}, {24'd0, r.d});
                chk("rvalid0_cycle", cyc, r.c);
            end
        end
        if (rvalid1) begin
            if (rq1.size() == 0) begin
                chk("unexpected_rvalid1", 32'd1, 32'd0);
            end else begin
                r = rq1.pop_front();
                chk("rdata1", {24'd0, rdata1}, {24'd0, r.d});
                chk("rvalid1_cycle", cyc, r.c);
            end
        end
    end

    // Present a transaction and wait (bounded) for its grant.
    task automatic txn(input int id, input logic we, input logic [2:0] a, input logic [7:0] d);
        if (id == 0) begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) return;
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout requester=%0d actual=no_grant expected=grant", id);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, "_rdata"},  {16'd0, rdata1, rdata0}, 32'd0);
        chk({tag, "_cs_we"},  {30'd0, ram_cs_n, ram_we_n}, 32'd3);
        chk({tag, "_addr"},   {29'd0, ram_addm}, 32'd0);
        chk({tag, "_din"},    {24'd0, ram_din}, 32'd0);
    endtask

    int s;

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x5A to address 3 from requester 0.
        s = cyc;
        exp_g(0, 1'b1, 3'd3, 8'h5A, s + 1);
        txn(0, 1'b1, 3'd3, 8'h5A);
        req0 = 1'b0;
        repeat (4) @(negedge clk);

        // Read it back.
        s = cyc;
        exp_g(0, 1'b0, 3'd3, 8'h00, s + 1);
        exp_r(0, 8'h5A, s + 3);
        txn(0, 1'b0, 3'd3, 8'h00);
        req0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("rdata0_hold", {24'd0, rdata0}, 32'h5A);

        // Reset (last grant was requester 0), then both write continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s = cyc;
        exp_g(0, 1'b1, 3'd1, 8'h11, s + 1);
        exp_g(1, 1'b1, 3'd2, 8'h22, s + 3);
        exp_g(0, 1'b1, 3'd1, 8'h11, s + 5);
        exp_g(1, 1'b1, 3'd2, 8'h22, s + 7);
        fork
            begin
                txn(0, 1'b1, 3'd1, 8'h11);
                txn(0, 1'b1, 3'd1, 8'h11);
                req0 = 1'b0;
            end
            begin
                txn(1, 1'b1, 3'd2, 8'h22);
                txn(1, 1'b1, 3'd2, 8'h22);
                req1 = 1'b0;
            end
        join
        repeat (4) @(negedge clk);

        // Same-address writes in grant order, then read back from requester 0.
        s = cyc;
        exp_g(0, 1'b1, 3'd5, 8'hA0, s + 1);
        exp_g(1, 1'b1, 3'd5, 8'hB1, s + 3);
        exp_g(0, 1'b0, 3'd5, 8'h00, s + 5);
        exp_r(0, 8'hB1, s + 7);
        fork
            begin
                txn(0, 1'b1, 3'd5, 8'hA0);
                txn(0, 1'b0, 3'd5, 8'h00);
                req0 = 1'b0;
            end
            begin
                txn(1, 1'b1, 3'd5, 8'hB1);
                req1 = 1'b0;
            end
        join
        repeat (6) @(negedge clk);

        // Requester 1 read aborted by reset during RDCAP.
        s = cyc;
        exp_g(1, 1'b0, 3'd2, 8'h00, s + 1);
        txn(1, 1'b0, 3'd2, 8'h00);
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rdata1_after_abort", {24'd0, rdata1}, 32'd0);
        s = cyc;
        exp_g(0, 1'b1, 3'd6, 8'h66, s + 1);
        exp_g(1, 1'b1, 3'd7, 8'h77, s + 3);
        fork
            begin txn(0, 1'b1, 3'd6, 8'h66); req0 = 1'b0; end
            begin txn(1, 1'b1, 3'd7, 8'h77); req1 = 1'b0; end
        join
        repeat (4) @(negedge clk);

        // Requester 1 alone: 8 back-to-back writes, then 8 reads.
        s = cyc;
        for (int k = 0; k < 8; k++) begin
            exp_g(1, 1'b1, 3'(k), 8'(k + 1), s + 1 + 2 * k);
        end
        for (int k = 0; k < 8; k++) begin
            exp_g(1, 1'b0, 3'(k), 8'h00, s + 17 + 3 * k);
            exp_r(1, 8'(k + 1), s + 19 + 3 * k);
        end
        for (int k = 0; k < 8; k++) txn(1, 1'b1, 3'(k), 8'(k + 1));
        for (int k = 0; k < 8; k++) txn(1, 1'b0, 3'(k), 8'h00);
        req1 = 1'b0;
        repeat (8) @(negedge clk);

        chk("pending_grants", gq.size(), 32'd0);
        chk("pending_reads0", rq0.size(), 32'd0);
        chk("pending_reads1", rq1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_single_arbiter.md
Name: ram_single_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the single-port synchronous RAM (`ram_single`: 8 words x 8 bits, active-low `cs_n`/`we_n`).
- Each requester issues one read or write at a time over a level-request / pulse-grant handshake. The arbiter drives the RAM port and returns registered read data with a one-cycle valid strobe.
- Sits between two client blocks and one `ram_single` instance.

Parameters:
- ADDR_W, 3, RAM address width (depth 2^ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 transaction request; level, held until gnt0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 high.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- gnt0  output  1  one-cycle pulse; requester 0 access is on the RAM this cycle.
- rvalid0  output  1  one-cycle pulse; rdata0 holds requester 0 read result.
- rdata0  output  DATA_W  requester 0 read data; holds value between pulses.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the port-0 signals, for requester 1.
- ram_addm  output  ADDR_W  RAM address.
- ram_cs_n  output  1  RAM chip select, active low.
- ram_we_n  output  1  RAM write enable, active low (1 = read).
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data, valid the cycle after a read access.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; rr_last = 1, so requester 0 wins the first tie.
  - ram_cs_n=1, ram_we_n=1, ram_addm=0, ram_din=0.
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - Any in-flight transaction is dropped and not retried.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, RDCAP.
- IDLE:
  - ram_cs_n=1.
  - If any req is high, pick a winner:
    - only one req high -> that requester wins;
    - both high -> the requester other than rr_last wins.
  - At the edge: load ram_addm/ram_din/ram_we_n (= ~we) from the winner, set ram_cs_n=0, set the winner's gnt, set rr_last=winner, go to ACCESS.
  - No req -> stay in IDLE.
- ACCESS (exactly one cycle):
  - ram_cs_n=0 and the winner's gnt=1.
  - Write -> IDLE.
  - Read -> RDCAP.
  - At the exit edge: ram_cs_n<=1, gnt<=0.
- RDCAP (one cycle):
  - ram_dout is valid.
  - At the exit edge: rdata_w<=ram_dout, rvalid_w<=1 for the winner; go to IDLE.
  - rvalid is high during the following IDLE cycle, so arbitration overlaps with it.
- Handshake rules:
  - Requester keeps req/we/addr/wdata stable until it samples gnt=1.
  - On that edge it either drops req or presents its next transaction.
  - A req that is still high in the cycle after gnt is treated as a new transaction.
- Latency, measured from req sampled high in IDLE:
  - gnt: +1 cycle.
  - rvalid: +3 cycles.
- Throughput:
  - write: one per 2 cycles;
  - read: one per 3 cycles.
- Fairness:
  - With both requesting continuously, grants strictly alternate.
  - Neither requester waits more than one transaction.
- Non-winner's gnt/rvalid stay 0. rvalid never pulses for writes.
- ram_we_n returns to 1 whenever ram_cs_n=1.
- Same-address accesses are served in grant order: a read granted after a write returns the written data.
- Address is used as-is; no wrap or range check (full ADDR_W range valid).

Test Plan:
- Reset, then req0 write addr=3 data=0x5A.
  - Expect: gnt0 one cycle after req0 is sampled; ram_cs_n=0, ram_we_n=0, ram_addm=3, ram_din=0x5A in that same cycle.
  - Expect: rvalid0 never asserts.
- After that write, req0 read addr=3.
  - Expect: gnt0 at +1 cycle with ram_we_n=1.
  - Expect: rvalid0 at +3 cycles with rdata0=0x5A; rdata0 holds 0x5A afterwards.
- req0 and req1 both assert writes in the same cycle after reset (addr 1/0x11, addr 2/0x22), each re-requesting immediately.
  - Expect: grant order 0,1,0,1, and never the same requester twice while the other waits.
- Both write addr 5: req0 data 0xA0 wins, then req1 data 0xB1; then read addr 5 from req0.
  - Expect: rdata0=0xB1.
- req1 read in flight; rst_n pulsed low during RDCAP.
  - Expect: all outputs return to reset values immediately; rvalid1 never pulses; the next req0 is granted first.
- Single requester with req1 held high for 8 back-to-back writes, addr 0..7, data 1..8.
  - Expect: gnt1 every 2nd cycle.
  - Expect: subsequent reads of 0..7 return 1..8 with rvalid1 every 3rd cycle.
